// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operations and datapath mux selects.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_JALR_PC,
    S_LUI, S_TRAP
  } state_t;

  // Which family of instruction the ALU decoder is interpreting func3 for.
  typedef enum logic [1:0] {CLS_ADD, CLS_R, CLS_I, CLS_BRANCH} alu_cls_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] RES_IMM     = 2'b11;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_REG    = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_S = 3'b001;
  localparam logic [2:0] EXT_B = 3'b010;
  localparam logic [2:0] EXT_J = 3'b011;
  localparam logic [2:0] EXT_U = 3'b100;

  function automatic logic [2:0] ext_from_opcode(input logic [6:0] op);
    case (op)
      OP_STORE:  return EXT_S;
      OP_BRANCH: return EXT_B;
      OP_JAL:    return EXT_J;
      OP_LUI:    return EXT_U;
      default:   return EXT_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from instruction class, func3 and func7[5].
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [2:0] func3,
  input  logic       alt,
  output logic [3:0] ALU_control
);

  always_comb begin
    ALU_control = ALU_ADD;
    case (cls)
      CLS_BRANCH: begin
        // beq/bne compare by subtraction, blt/bge by the slt result
        case (func3)
          3'b000, 3'b001: ALU_control = ALU_SUB;
          3'b100, 3'b101: ALU_control = ALU_SLT;
          default:        ALU_control = ALU_ADD;
        endcase
      end
      CLS_R, CLS_I: begin
        case (func3)
          3'b000:  ALU_control = (cls == CLS_R && alt) ? ALU_SUB : ALU_ADD;
          3'b001:  ALU_control = ALU_SLL;
          3'b010:  ALU_control = ALU_SLT;
          3'b011:  ALU_control = ALU_SLTU;
          3'b100:  ALU_control = ALU_XOR;
          3'b101:  ALU_control = alt ? ALU_SRA : ALU_SRL;
          3'b110:  ALU_control = ALU_OR;
          default: ALU_control = ALU_AND;
        endcase
      end
      default: ALU_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_controller.sv
// Moore FSM sequencing a shared-memory, shared-ALU multicycle RV32I datapath.
// Optional ILLEGAL_TRAP_EN: illegal encodings park in TRAP with illegal_instr=1.
module riscv_multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  output logic       PC_write,
  output logic       adr_src,
  output logic       IR_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] ALU_src_A,
  output logic [1:0] ALU_src_B,
  output logic [3:0] ALU_control,
  output logic [2:0] extend_src,
`ifdef ILLEGAL_TRAP_EN
  output logic       illegal_instr,
`endif
  output logic       instr_done
);

  state_t     state, next_state;
  alu_cls_t   cls;
  logic [3:0] dec_control;
  logic       branch_taken;

  assign cls = (state == S_EXEC_R) ? CLS_R :
               (state == S_EXEC_I) ? CLS_I :
               (state == S_BRANCH) ? CLS_BRANCH : CLS_ADD;

  alu_decoder u_alu_decoder (
    .cls         (cls),
    .func3       (func3),
    .alt         (func7[5]),
    .ALU_control (dec_control)
  );

  assign ALU_control = reset ? ALU_ADD : dec_control;

`ifdef ILLEGAL_TRAP_EN
  logic legal;

  always_comb begin
    legal = 1'b1;
    case (opcode)
      OP_LOAD, OP_STORE: legal = (func3 == 3'b010);
      OP_BRANCH:         legal = (func3 != 3'b010) && (func3 != 3'b011);
      OP_I: begin
        if (func3 == 3'b001)
          legal = (func7 == 7'b0000000);
        else if (func3 == 3'b101)
          legal = (func7 == 7'b0000000) || (func7 == 7'b0100000);
      end
      OP_R, OP_JAL, OP_JALR, OP_LUI: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign illegal_instr = !reset && (state == S_TRAP);
`else
  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};
`endif

  always_comb begin
    case (func3)
      3'b000, 3'b101: branch_taken = zero;
      3'b001, 3'b100: branch_taken = !zero;
      default:        branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    PC_write   = 1'b0;
    adr_src    = 1'b0;
    IR_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    result_src = RES_ALU_OUT;
    ALU_src_A  = SRC_A_PC;
    ALU_src_B  = SRC_B_REG;
    extend_src = EXT_I;
    // While reset is held every enable and select stays at zero.
    if (!reset) begin
      extend_src = ext_from_opcode(opcode);
      case (state)
        S_FETCH: begin
          IR_write   = 1'b1;
          PC_write   = 1'b1;
          ALU_src_B  = SRC_B_FOUR;
          result_src = RES_ALU;
          next_state = S_DECODE;
        end
        S_DECODE: begin
          ALU_src_A = SRC_A_OLD_PC;
          ALU_src_B = SRC_B_IMM;
          case (opcode)
            OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
            OP_R:              next_state = S_EXEC_R;
            OP_I:              next_state = S_EXEC_I;
            OP_BRANCH:         next_state = S_BRANCH;
            OP_JAL:            next_state = S_JAL;
            OP_JALR:           next_state = S_JALR;
            OP_LUI:            next_state = S_LUI;
            default:           next_state = S_FETCH;
          endcase
`ifdef ILLEGAL_TRAP_EN
          if (!legal) next_state = S_TRAP;
`endif
        end
        S_MEM_ADR: begin
          ALU_src_A  = SRC_A_REG;
          ALU_src_B  = SRC_B_IMM;
          next_state = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          adr_src    = 1'b1;
          next_state = S_MEM_WB;
        end
        S_MEM_WB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_MEM_WRITE: begin
          adr_src    = 1'b1;
          mem_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_EXEC_R: begin
          ALU_src_A  = SRC_A_REG;
          next_state = S_ALU_WB;
        end
        S_EXEC_I: begin
          ALU_src_A  = SRC_A_REG;
          ALU_src_B  = SRC_B_IMM;
          next_state = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          ALU_src_A  = SRC_A_REG;
          PC_write   = branch_taken;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        // jal/jalr_pc redirect PC to ALU_out while the ALU forms the link address
        S_JAL, S_JALR_PC: begin
          PC_write   = 1'b1;
          ALU_src_A  = SRC_A_OLD_PC;
          ALU_src_B  = SRC_B_FOUR;
          next_state = S_ALU_WB;
        end
        S_JALR: begin
          ALU_src_A  = SRC_A_REG;
          ALU_src_B  = SRC_B_IMM;
          next_state = S_JALR_PC;
        end
        S_LUI: begin
          result_src = RES_IMM;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_TRAP:  next_state = S_TRAP;
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Scoreboard bench: stimulus pushes per-cycle expected control words derived
// from the instruction timing table; a negedge monitor pops and compares.
module tb_riscv_multicycle_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic [6:0] func7 = 7'd0;
  logic       zero = 1'b0;
  logic       PC_write, adr_src, IR_write, mem_write, reg_write, instr_done;
  logic [1:0] result_src, ALU_src_A, ALU_src_B;
  logic [3:0] ALU_control;
  logic [2:0] extend_src;
  logic       illegal_instr;

  always #5 clock = ~clock;

  riscv_multicycle_controller dut (
    .clock       (clock),
    .reset       (reset),
    .opcode      (opcode),
    .func3       (func3),
    .func7       (func7),
    .zero        (zero),
    .PC_write    (PC_write),
    .adr_src     (adr_src),
    .IR_write    (IR_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .ALU_src_A   (ALU_src_A),
    .ALU_src_B   (ALU_src_B),
    .ALU_control (ALU_control),
    .extend_src  (extend_src),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr (illegal_instr),
`endif
    .instr_done  (instr_done)
  );

`ifndef ILLEGAL_TRAP_EN
  assign illegal_instr = 1'b0;
`endif

  typedef struct packed {
    logic       pcw, adr, irw, memw, regw;
    logic [1:0] rsrc, sa, sb;
    logic [3:0] alu;
    logic [2:0] ext;
    logic       done, ill;
  } ctl_t;

  ctl_t  exp_q[$];
  string name_q[$];
  ctl_t  seq[$];
  int    checks = 0;
  int    passed = 0;

  function automatic ctl_t idle(input logic [2:0] ext);
    ctl_t c;
    c = '0;
    c.ext = ext;
    return c;
  endfunction

  function automatic logic [2:0] ext_of(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b1101111: return 3'd3;
      7'b0110111: return 3'd4;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] exec_alu(input logic is_r, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'd0:    return (is_r && f7[5]) ? 4'd1 : 4'd0;
      3'd1:    return 4'd7;
      3'd2:    return 4'd5;
      3'd3:    return 4'd6;
      3'd4:    return 4'd4;
      3'd5:    return f7[5] ? 4'd9 : 4'd8;
      3'd6:    return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

`ifdef ILLEGAL_TRAP_EN
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    case (op)
      7'b0000011, 7'b0100011: return f3 == 3'd2;
      7'b1100011: return f3 != 3'd2 && f3 != 3'd3;
      7'b0010011:
        if (f3 == 3'd1) return f7 == 7'd0;
        else if (f3 == 3'd5) return f7 == 7'd0 || f7 == 7'h20;
        else return 1'b1;
      7'b0110011, 7'b1101111, 7'b1100111, 7'b0110111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
`endif

  // Expected control word for every cycle of one instruction.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic z);
    ctl_t c, wb;
    logic [2:0] e;
    e = ext_of(op);
    seq.delete();
    c = idle(e); c.irw = 1; c.pcw = 1; c.sb = 2; c.rsrc = 2; seq.push_back(c);
    c = idle(e); c.sa = 1; c.sb = 1; seq.push_back(c);
`ifdef ILLEGAL_TRAP_EN
    if (!is_legal(op, f3, f7)) begin
      repeat (3) begin c = idle(e); c.ill = 1; seq.push_back(c); end
      return;
    end
`endif
    wb = idle(e); wb.regw = 1; wb.done = 1;
    case (op)
      7'b0000011: begin
        c = idle(e); c.sa = 2; c.sb = 1; seq.push_back(c);
        c = idle(e); c.adr = 1; seq.push_back(c);
        c = idle(e); c.rsrc = 1; c.regw = 1; c.done = 1; seq.push_back(c);
      end
      7'b0100011: begin
        c = idle(e); c.sa = 2; c.sb = 1; seq.push_back(c);
        c = idle(e); c.adr = 1; c.memw = 1; c.done = 1; seq.push_back(c);
      end
      7'b0110011: begin
        c = idle(e); c.sa = 2; c.alu = exec_alu(1'b1, f3, f7); seq.push_back(c);
        seq.push_back(wb);
      end
      7'b0010011: begin
        c = idle(e); c.sa = 2; c.sb = 1; c.alu = exec_alu(1'b0, f3, f7); seq.push_back(c);
        seq.push_back(wb);
      end
      7'b1100011: begin
        c = idle(e); c.sa = 2; c.done = 1;
        case (f3)
          3'd0: begin c.alu = 4'd1; c.pcw = z;  end
          3'd1: begin c.alu = 4'd1; c.pcw = !z; end
          3'd4: begin c.alu = 4'd5; c.pcw = !z; end
          3'd5: begin c.alu = 4'd5; c.pcw = z;  end
          default: ;
        endcase
        seq.push_back(c);
      end
      7'b1101111: begin
        c = idle(e); c.pcw = 1; c.sa = 1; c.sb = 2; seq.push_back(c);
        seq.push_back(wb);
      end
      7'b1100111: begin
        c = idle(e); c.sa = 2; c.sb = 1; seq.push_back(c);
        c = idle(e); c.pcw = 1; c.sa = 1; c.sb = 2; seq.push_back(c);
        seq.push_back(wb);
      end
      7'b0110111: begin
        c = idle(e); c.rsrc = 3; c.regw = 1; c.done = 1; seq.push_back(c);
      end
      default: ;
    endcase
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(idle(3'd0));
      name_q.push_back($sformatf("reset_c%0d", i + 1));
    end
    step(n);
    reset = 1'b0;
  endtask

  // abort_at >= 0 asserts reset in that (0-based) cycle of the instruction.
  task automatic run(input string nm, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic z, input int abort_at);
    int n;
    logic trapped;
    opcode = op; func3 = f3; func7 = f7; zero = z;
    build(op, f3, f7, z);
    n = seq.size();
    trapped = seq[n-1].ill;
    if (abort_at >= 0 && abort_at < n) n = abort_at;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(seq[i]);
      name_q.push_back($sformatf("%s_c%0d", nm, i + 1));
    end
    step(n);
    if (n < seq.size() || trapped) apply_reset(2);
  endtask

  always @(negedge clock) begin
    ctl_t  e, a;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {PC_write, adr_src, IR_write, mem_write, reg_write, result_src,
            ALU_src_A, ALU_src_B, ALU_control, extend_src, instr_done, illegal_instr};
      checks++;
      if (a === e) passed++;
      else $display("FAIL %s: got %b required %b (pcw adr irw memw regw rsrc sa sb alu ext done ill)",
                    nm, a, e);
    end
  end

  logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0000000, 7'b1111111};

  initial begin
    logic [6:0] op, f7;
    int abort_at;
    opcode = 7'b0110011; func3 = 3'b000; func7 = 7'b0100000;
    @(posedge clock);
    #1;
    apply_reset(2);
    run("sub",        7'b0110011, 3'b000, 7'b0100000, 1'b0, -1);
    run("lw",         7'b0000011, 3'b010, 7'b0000000, 1'b0, -1);
    run("sw",         7'b0100011, 3'b010, 7'b0000000, 1'b1, -1);
    run("beq_taken",  7'b1100011, 3'b000, 7'b0000000, 1'b1, -1);
    run("bge_nt",     7'b1100011, 3'b101, 7'b0000000, 1'b0, -1);
    run("blt",        7'b1100011, 3'b100, 7'b0000000, 1'b0, -1);
    run("jal",        7'b1101111, 3'b000, 7'b0000000, 1'b0, -1);
    run("jalr",       7'b1100111, 3'b000, 7'b0000000, 1'b0, -1);
    run("lui",        7'b0110111, 3'b000, 7'b0000000, 1'b0, -1);
    run("srai",       7'b0010011, 3'b101, 7'b0100000, 1'b0, -1);
    run("sw_abort",   7'b0100011, 3'b010, 7'b0000000, 1'b0, 2);
    run("unknown",    7'b1111111, 3'b000, 7'b0000000, 1'b0, -1);
    run("after_unk",  7'b0110011, 3'b111, 7'b0000000, 1'b0, -1);
    for (int k = 0; k < 80; k++) begin
      op = ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 2))
        0:       f7 = 7'b0000000;
        1:       f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      run($sformatf("rnd%0d", k), op, 3'($urandom), f7, 1'($urandom), abort_at);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(1);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
